// File: rtl/secant_search_fx.sv
// Fixed-point secant-method search controller for the front-end control loop.
// Drives the reference i_ref, requests one plant measurement per trial point and iterates
// c = b - f_b*(b-a)/(f_b-f_a) until |q_measured - q_desired| < TOL, then tracks the point and
// restarts the search if the tracked error drifts out of tolerance.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   enable            search enable (level); low returns to IDLE on the next edge
//   q_desired         target value (unsigned, sampled live)
//   q_measured        plant measurement, valid only while ready=1
//   ready             one-cycle pulse answering the last meas_req
//   i_ref             registered current reference
//   meas_req          one-cycle pulse: measure at the current i_ref
//   converged         high while tracking
//   went_unstable     sticky failure flag, cleared when the next search starts
//   busy              high in every state except IDLE and FAIL
//   iter_count        secant iterations since the last (re)start
module secant_search_fx #(
    parameter int BUS_WIDTH     = 10,
    parameter int TOL           = 30,
    parameter int MAX_ITER      = 16,
    parameter int DIVERGE_LIMIT = 3,
    parameter int ITER_W        = $clog2(MAX_ITER + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [BUS_WIDTH-1:0] q_desired,
    input  logic [BUS_WIDTH-1:0] q_measured,
    input  logic                 ready,
    output logic [BUS_WIDTH-1:0] i_ref,
    output logic                 meas_req,
    output logic                 converged,
    output logic                 went_unstable,
    output logic                 busy,
    output logic [ITER_W-1:0]    iter_count
);

    localparam int PW      = 2 * BUS_WIDTH + 2;  // product / dividend width
    localparam int DENW    = BUS_WIDTH + 2;      // slope denominator width
    localparam int CNT_W   = $clog2(PW + 2);
    localparam int STALL_W = $clog2(DIVERGE_LIMIT + 1);

    localparam logic [BUS_WIDTH-1:0] IMAX       = '1;
    localparam logic [BUS_WIDTH:0]   TOL_V      = (BUS_WIDTH + 1)'(TOL);
    localparam logic [STALL_W-1:0]   LIMIT_V    = STALL_W'(DIVERGE_LIMIT);
    localparam logic [ITER_W-1:0]    MAX_ITER_V = ITER_W'(MAX_ITER);
    localparam logic [CNT_W-1:0]     CNT_LAST   = CNT_W'(PW);
    localparam logic [CNT_W-1:0]     CNT_ONE    = CNT_W'(1);

    typedef enum logic [3:0] {
        StIdle, StProbeA, StWaitA, StProbeB, StWaitB, StCalc,
        StProbeC, StWaitC, StCheck, StTrack, StFail
    } state_e;

    state_e state_q, state_d;

    logic [BUS_WIDTH-1:0]        i_ref_q, i_ref_d, a_q, a_d, b_q, b_d, c_q, c_d;
    logic signed [BUS_WIDTH:0]   f_a_q, f_a_d, f_b_q, f_b_d, f_c_q, f_c_d;
    logic                        meas_req_q, meas_req_d, unst_q, unst_d;
    logic                        track_wait_q, track_wait_d;
    logic [ITER_W-1:0]           iter_q, iter_d;
    logic [STALL_W-1:0]          stall_q, stall_d, stall_nxt;
    // Restoring divider state: dividend shifts out of quo_q MSB-first, quotient shifts in.
    logic [PW-1:0]               quo_q, quo_d;
    logic [DENW-1:0]             rem_q, rem_d, dvs_q, dvs_d;
    logic                        neg_q, neg_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;

    function automatic logic [BUS_WIDTH:0] abs_v(input logic signed [BUS_WIDTH:0] v);
        return v[BUS_WIDTH] ? -v : v;
    endfunction

    logic signed [BUS_WIDTH:0]   err, ab_diff;
    logic [BUS_WIDTH:0]          abs_err, abs_fb, abs_fc;
    logic signed [PW-1:0]        prod;
    logic signed [DENW-1:0]      den;
    logic [PW-1:0]               num_mag;
    logic [DENW-1:0]             den_mag, rem_sub;
    logic [DENW:0]               rem_sh;
    logic                        rem_ge;
    logic signed [PW:0]          q_signed;
    logic signed [PW+1:0]        c_wide;
    logic [BUS_WIDTH-1:0]        c_clamp;

    assign err     = $signed({1'b0, q_measured}) - $signed({1'b0, q_desired});
    assign abs_err = abs_v(err);
    assign abs_fb  = abs_v(f_b_q);
    assign abs_fc  = abs_v(f_c_q);
    assign ab_diff = $signed({1'b0, b_q}) - $signed({1'b0, a_q});
    assign prod    = PW'(f_b_q) * PW'(ab_diff);
    assign den     = DENW'(f_b_q) - DENW'(f_a_q);
    assign num_mag = prod[PW-1] ? -prod : prod;
    assign den_mag = den[DENW-1] ? -den : den;
    assign rem_sh  = {rem_q, quo_q[PW-1]};
    assign rem_ge  = rem_sh >= {1'b0, dvs_q};
    // Once rem_sh >= dvs the difference is below dvs, so the low bits are exact.
    assign rem_sub = rem_sh[DENW-1:0] - dvs_q;
    // Magnitude quotient with sign reapplied gives truncation toward zero.
    assign q_signed = neg_q ? -$signed({1'b0, quo_q}) : $signed({1'b0, quo_q});
    assign c_wide   = (PW + 2)'($signed({1'b0, b_q})) - (PW + 2)'(q_signed);
    assign c_clamp  = c_wide[PW+1]               ? '0   :
                      (|c_wide[PW:BUS_WIDTH])    ? IMAX : c_wide[BUS_WIDTH-1:0];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state and datapath next values
    always_comb begin
        state_d      = state_q;
        i_ref_d      = i_ref_q;
        meas_req_d   = 1'b0;
        unst_d       = unst_q;
        iter_d       = iter_q;
        a_d          = a_q;
        b_d          = b_q;
        c_d          = c_q;
        f_a_d        = f_a_q;
        f_b_d        = f_b_q;
        f_c_d        = f_c_q;
        stall_d      = stall_q;
        stall_nxt    = stall_q;
        track_wait_d = track_wait_q;
        quo_d        = quo_q;
        rem_d        = rem_q;
        dvs_d        = dvs_q;
        neg_d        = neg_q;
        cnt_d        = '0;
        if (!enable) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    unst_d  = 1'b0;
                    iter_d  = '0;
                    a_d     = '0;
                    b_d     = IMAX;
                    stall_d = '0;
                    state_d = StProbeA;
                end
                StProbeA: begin
                    i_ref_d    = a_q;
                    meas_req_d = 1'b1;
                    state_d    = StWaitA;
                end
                StWaitA: if (ready) begin
                    f_a_d   = err;
                    state_d = StProbeB;
                end
                StProbeB: begin
                    i_ref_d    = b_q;
                    meas_req_d = 1'b1;
                    state_d    = StWaitB;
                end
                StWaitB: if (ready) begin
                    f_b_d = err;
                    if (abs_err < TOL_V) begin
                        c_d          = b_q;
                        track_wait_d = 1'b0;
                        state_d      = StTrack;
                    end else begin
                        state_d = StCalc;
                    end
                end
                StCalc: begin
                    if (cnt_q == '0) begin
                        if (f_b_q == f_a_q) begin
                            unst_d  = 1'b1;
                            state_d = StFail;
                        end else begin
                            quo_d = num_mag;
                            rem_d = '0;
                            dvs_d = den_mag;
                            neg_d = prod[PW-1] ^ den[DENW-1];
                            cnt_d = CNT_ONE;
                        end
                    end else if (cnt_q <= CNT_LAST) begin
                        rem_d = rem_ge ? rem_sub : rem_sh[DENW-1:0];
                        quo_d = {quo_q[PW-2:0], rem_ge};
                        cnt_d = cnt_q + 1'b1;
                    end else begin
                        c_d     = c_clamp;
                        iter_d  = iter_q + 1'b1;
                        state_d = StProbeC;
                    end
                end
                StProbeC: begin
                    i_ref_d    = c_q;
                    meas_req_d = 1'b1;
                    state_d    = StWaitC;
                end
                StWaitC: if (ready) begin
                    f_c_d   = err;
                    state_d = StCheck;
                end
                StCheck: begin
                    if (abs_fc < TOL_V) begin
                        track_wait_d = 1'b0;
                        state_d      = StTrack;
                    end else begin
                        stall_nxt = (abs_fc >= abs_fb) ? stall_q + 1'b1 : '0;
                        stall_d   = stall_nxt;
                        if (stall_nxt == LIMIT_V || iter_q == MAX_ITER_V) begin
                            unst_d  = 1'b1;
                            state_d = StFail;
                        end else begin
                            a_d     = b_q;
                            f_a_d   = f_b_q;
                            b_d     = c_q;
                            f_b_d   = f_c_q;
                            state_d = StCalc;
                        end
                    end
                end
                StTrack: begin
                    // track_wait_q marks an outstanding tracking request.
                    if (!track_wait_q) begin
                        meas_req_d   = 1'b1;
                        track_wait_d = 1'b1;
                    end else if (ready) begin
                        if (abs_err >= TOL_V) begin
                            a_d     = '0;
                            b_d     = IMAX;
                            iter_d  = '0;
                            stall_d = '0;
                            state_d = StProbeA;
                        end else begin
                            meas_req_d = 1'b1;
                        end
                    end
                end
                StFail:  state_d = StFail;
                default: state_d = StIdle;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_ref_q      <= '0;
            meas_req_q   <= 1'b0;
            unst_q       <= 1'b0;
            iter_q       <= '0;
            a_q          <= '0;
            b_q          <= IMAX;
            c_q          <= '0;
            f_a_q        <= '0;
            f_b_q        <= '0;
            f_c_q        <= '0;
            stall_q      <= '0;
            track_wait_q <= 1'b0;
            quo_q        <= '0;
            rem_q        <= '0;
            dvs_q        <= '0;
            neg_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            i_ref_q      <= i_ref_d;
            meas_req_q   <= meas_req_d;
            unst_q       <= unst_d;
            iter_q       <= iter_d;
            a_q          <= a_d;
            b_q          <= b_d;
            c_q          <= c_d;
            f_a_q        <= f_a_d;
            f_b_q        <= f_b_d;
            f_c_q        <= f_c_d;
            stall_q      <= stall_d;
            track_wait_q <= track_wait_d;
            quo_q        <= quo_d;
            rem_q        <= rem_d;
            dvs_q        <= dvs_d;
            neg_q        <= neg_d;
            cnt_q        <= cnt_d;
        end
    end

    // Outputs
    always_comb begin
        i_ref         = i_ref_q;
        meas_req      = meas_req_q;
        converged     = (state_q == StTrack);
        went_unstable = unst_q;
        busy          = (state_q != StIdle) && (state_q != StFail);
        iter_count    = iter_q;
    end

endmodule

// File: tb/tb_secant_search_fx.sv
module tb_secant_search_fx;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [9:0] q_desired;
    logic [9:0] q_measured;
    logic       ready;
    logic [9:0] i_ref;
    logic       meas_req;
    logic       converged;
    logic       went_unstable;
    logic       busy;
    logic [4:0] iter_count;

    secant_search_fx #(
        .BUS_WIDTH    (10),
        .TOL          (30),
        .MAX_ITER     (16),
        .DIVERGE_LIMIT(3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .q_desired    (q_desired),
        .q_measured   (q_measured),
        .ready        (ready),
        .i_ref        (i_ref),
        .meas_req     (meas_req),
        .converged    (converged),
        .went_unstable(went_unstable),
        .busy         (busy),
        .iter_count   (iter_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int plant;
        int qd;
        int conv;
        int iref;
        int iter;
        int unst;
        int reqs;  // -1: not checked (tracking keeps requesting)
    } vec_t;

    vec_t vecs[9];
    int   checks = 0;
    int   errors = 0;
    int   req_count = 0;
    bit   pend = 0;
    int   req_iref = 0;
    bit   auto_plant = 1;
    int   plant_sel = 0;
    bit   ok;
    int   rc;

    // 0 identity, 1 i/2+100, 2 flat 200, 3 step at 512, 4 i/4
    function automatic int plant(input int sel, input int i);
        case (sel)
            0: return i;
            1: return i / 2 + 100;
            2: return 200;
            3: return (i < 512) ? 0 : 1023;
            default: return i / 4;
        endcase
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One clock; outputs sampled 1 ns after the edge. In auto mode the plant answers each
    // meas_req with a one-cycle ready on the following cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (auto_plant) begin
            ready = 1'b0;
            if (pend) begin
                ready      = 1'b1;
                q_measured = 10'(plant(plant_sel, req_iref));
                pend       = 0;
            end
        end
        if (meas_req) begin
            req_count++;
            if (auto_plant) begin
                chk("req_before_ready", int'(pend), 0);
                pend     = 1;
                req_iref = int'(i_ref);
            end
        end
    endtask

    task automatic clear_plant();
        pend  = 0;
        ready = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit done);
        done = 0;
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (converged || (went_unstable && !busy)) begin
                done = 1;
                break;
            end
        end
    endtask

    task automatic wait_req(input int budget, output bit done);
        done = 0;
        for (int i = 0; i < budget; i++) begin
            cyc();
            if (meas_req) begin
                done = 1;
                break;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got 0 expected 1");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{0, 500, 1, 500, 1, 0, -1};
        vecs[1] = '{1, 300, 1, 401, 1, 0, -1};
        vecs[2] = '{0, 0, 1, 0, 1, 0, -1};
        vecs[3] = '{0, 1023, 1, 1023, 0, 0, -1};
        vecs[4] = '{0, 993, 1, 993, 1, 0, -1};      // |f_b| = 30: not converged
        vecs[5] = '{0, 994, 1, 1023, 0, 0, -1};     // |f_b| = 29: converged at b
        vecs[6] = '{2, 600, 0, 1023, 0, 1, 2};      // flat plant, equal slopes
        vecs[7] = '{3, 600, 0, 600, 1, 1, 3};       // step plant stalls
        vecs[8] = '{4, 300, 0, 1023, 1, 1, 3};      // c = 1203 clamps to 1023

        rst = 1'b1;
        enable = 1'b0;
        q_desired = '0;
        q_measured = '0;
        ready = 1'b0;
        cyc();
        cyc();
        chk("rst_i_ref", int'(i_ref), 0);
        chk("rst_meas_req", int'(meas_req), 0);
        chk("rst_converged", int'(converged), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_unstable", int'(went_unstable), 0);
        chk("rst_iter", int'(iter_count), 0);
        rst = 1'b0;

        for (int k = 0; k < 9; k++) begin
            enable = 1'b0;
            cyc();
            cyc();
            clear_plant();
            plant_sel = vecs[k].plant;
            q_desired = 10'(vecs[k].qd);
            req_count = 0;
            enable = 1'b1;
            wait_done(3000, ok);
            chk($sformatf("v%0d_done", k), int'(ok), 1);
            repeat (4) cyc();
            chk($sformatf("v%0d_converged", k), int'(converged), vecs[k].conv);
            chk($sformatf("v%0d_i_ref", k), int'(i_ref), vecs[k].iref);
            chk($sformatf("v%0d_iter", k), int'(iter_count), vecs[k].iter);
            chk($sformatf("v%0d_unstable", k), int'(went_unstable), vecs[k].unst);
            chk($sformatf("v%0d_busy", k), int'(busy), vecs[k].conv);
            if (vecs[k].reqs >= 0)
                chk($sformatf("v%0d_req_count", k), req_count, vecs[k].reqs);
        end

        // went_unstable holds through IDLE, clears when the next search starts
        enable = 1'b0;
        cyc();
        cyc();
        chk("idle_unstable_held", int'(went_unstable), 1);
        chk("idle_busy", int'(busy), 0);
        enable = 1'b1;
        cyc();
        chk("restart_unstable_clr", int'(went_unstable), 0);
        chk("restart_busy", int'(busy), 1);

        // Retarget while tracking
        enable = 1'b0;
        cyc();
        cyc();
        clear_plant();
        plant_sel = 0;
        q_desired = 10'd500;
        enable = 1'b1;
        wait_done(3000, ok);
        chk("rt_first_conv", int'(converged), 1);
        repeat (3) cyc();
        q_desired = 10'd700;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (!converged) begin
                ok = 1;
                break;
            end
        end
        chk("rt_conv_dropped", int'(ok), 1);
        rc = req_count;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (req_count > rc) begin
                ok = 1;
                break;
            end
        end
        chk("rt_restart_req", int'(ok), 1);
        chk("rt_restart_i_ref", req_iref, 0);
        wait_done(3000, ok);
        repeat (2) cyc();
        chk("rt_converged", int'(converged), 1);
        chk("rt_i_ref", int'(i_ref), 700);
        chk("rt_unstable", int'(went_unstable), 0);
        chk("rt_iter", int'(iter_count), 1);

        // Stray ready outside WAIT states, hand-driven handshake
        enable = 1'b0;
        cyc();
        cyc();
        auto_plant = 0;
        clear_plant();
        q_desired = 10'd500;
        req_count = 0;
        ready = 1'b1;
        q_measured = 10'd500;
        cyc();
        cyc();
        chk("sr_idle_busy", int'(busy), 0);
        enable = 1'b1;
        wait_req(10, ok);
        ready = 1'b0;
        chk("sr_req_a", int'(ok), 1);
        chk("sr_i_ref_a", int'(i_ref), 0);
        repeat (3) begin
            cyc();
            chk("sr_wait_a_no_rereq", int'(meas_req), 0);
        end
        ready = 1'b1;
        q_measured = 10'd0;
        cyc();
        ready = 1'b0;
        wait_req(10, ok);
        chk("sr_req_b", int'(ok), 1);
        chk("sr_i_ref_b", int'(i_ref), 1023);
        ready = 1'b1;
        q_measured = 10'd1023;
        cyc();
        q_measured = 10'd0;  // garbage held on ready through CALC and PROBE_C
        wait_req(100, ok);
        ready = 1'b0;
        chk("sr_req_c", int'(ok), 1);
        chk("sr_i_ref_c", int'(i_ref), 500);
        chk("sr_req_count", req_count, 3);
        cyc();
        cyc();
        ready = 1'b1;
        q_measured = 10'd500;
        cyc();
        q_measured = 10'd0;  // lands in CHECK
        cyc();
        ready = 1'b0;
        cyc();
        chk("sr_converged", int'(converged), 1);
        chk("sr_i_ref", int'(i_ref), 500);
        chk("sr_iter", int'(iter_count), 1);

        // Reset during CALC
        enable = 1'b0;
        cyc();
        cyc();
        auto_plant = 1;
        clear_plant();
        req_count = 0;
        enable = 1'b1;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (req_count == 2) begin
                ok = 1;
                break;
            end
        end
        chk("rc_reached_b", int'(ok), 1);
        repeat (8) cyc();
        chk("rc_busy_before", int'(busy), 1);
        rst = 1'b1;
        #1;
        chk("rc_i_ref", int'(i_ref), 0);
        chk("rc_meas_req", int'(meas_req), 0);
        chk("rc_converged", int'(converged), 0);
        chk("rc_busy", int'(busy), 0);
        chk("rc_unstable", int'(went_unstable), 0);
        chk("rc_iter", int'(iter_count), 0);
        enable = 1'b0;
        cyc();
        rst = 1'b0;
        clear_plant();
        auto_plant = 0;
        ready = 1'b1;
        q_measured = 10'd0;
        cyc();
        ready = 1'b0;
        cyc();
        chk("rc_late_ready_busy", int'(busy), 0);
        auto_plant = 1;
        req_count = 0;
        enable = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (req_count > 0) begin
                ok = 1;
                break;
            end
        end
        chk("rc_new_req", int'(ok), 1);
        chk("rc_new_i_ref", req_iref, 0);
        wait_done(3000, ok);
        chk("rc_reconverged", int'(converged), 1);
        chk("rc_reconv_i_ref", int'(i_ref), 500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
